mc_controller: RTL
==================

# mc_controller

Multicycle control unit for the RV32I core variant that shares one ALU and one memory port across instruction phases. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback states. Every cycle it drives the datapath mux selects, the write strobes, `imm_src` for the immediate extender and `alu_control` for the ALU. It sits beside the datapath and takes `op`/`funct3`/`funct7b5` from the instruction register and `zero` from the ALU.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `op`  in  7  instruction opcode (instr[6:0]) from instruction register
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory handshake (used only with `MC_CTRL_MEM_WAIT_EN`)
- `imm_src`  out  2  00 I, 01 S, 10 B, 11 J
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 rs1 (A reg)
- `alu_src_b`  out  2  00 rs2 (WriteData reg), 01 ImmExt, 10 constant 4
- `result_src`  out  2  00 ALUOut, 01 Data reg, 10 ALUResult
- `adr_src`  out  1  0 PC, 1 Result
- `alu_control`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `ir_write`, `pc_write`, `reg_write`, `mem_write`  out  1 each  write strobes
- `instr_retire`  out  1  one-cycle pulse when an instruction completes
- `illegal_instr`  out  1  high while in TRAP

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, TRAP.
- Transitions:
  - FETCH→DECODE.
  - DECODE by `op`: 0000011 or 0100011→MEMADR; 0110011→EXECUTER; 0010011→EXECUTEI; 1101111→JAL; 1100011→BEQ; any other value→TRAP.
  - MEMADR: `op`=0000011→MEMREAD, else MEMWRITE.
  - MEMREAD→MEMWB→FETCH. MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH. JAL→ALUWB. BEQ→FETCH.
  - TRAP holds until `reset`.
- Per-state outputs. Any output not listed is 0; `alu_op` is internal.
  - FETCH: adr_src 0, ir_write 1, src_a 00, src_b 10, alu_op 00, result_src 10, pc_update 1.
  - DECODE: src_a 01, src_b 01, alu_op 00.
  - MEMADR: src_a 10, src_b 01, alu_op 00.
  - MEMREAD: result_src 00, adr_src 1.
  - MEMWB: result_src 01, reg_write 1.
  - MEMWRITE: result_src 00, adr_src 1, mem_write 1.
  - EXECUTER: src_a 10, src_b 00, alu_op 10.
  - EXECUTEI: src_a 10, src_b 01, alu_op 10.
  - ALUWB: result_src 00, reg_write 1.
  - JAL: src_a 01, src_b 10, alu_op 00, result_src 00, pc_update 1.
  - BEQ: src_a 10, src_b 00, alu_op 01, result_src 00, branch 1.
- `pc_write` = pc_update | (branch & zero).
- `imm_src` is combinational from `op` in every state: 0100011→01, 1100011→10, 1101111→11, all others→00.
- `alu_control` from `alu_op`:
  - 00→add; 01→sub.
  - 10 by `funct3`: 000→sub if `op[5]&funct7b5`, else add; 010→slt; 110→or; 111→and; others→add.
- `instr_retire` is high in MEMWB, ALUWB, BEQ, and in MEMWRITE on its completing cycle.

## Timing
- Cycle counts: lw 5, sw 4, R/I-type 4, jal 4, beq 3.
- Outputs are decoded from the state register only, with no input-to-output paths except these:
  - `imm_src` from `op`;
  - `alu_control` from `funct3`, `op[5]` and `funct7b5`;
  - `pc_write` from `zero`;
  - `mem_ready` gating, when the macro is defined.
- Reset:
  - The cycle after `reset` is sampled high, state = FETCH.
  - While `reset` is high, all write strobes, `instr_retire` and `illegal_instr` are forced to 0; muxes show FETCH values.
  - Reset asserted in any state, including mid-instruction or TRAP, abandons the instruction with no further writes.
- A taken BEQ and the FETCH increment never coincide: they are in different states.

## Configuration
- `MC_CTRL_MEM_WAIT_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold until `mem_ready`=1.
  - In FETCH, `ir_write` and `pc_update` assert only in the cycle `mem_ready`=1.
  - `mem_write` stays high throughout MEMWRITE.
  - MEMWRITE `instr_retire` pulses only in its `mem_ready` cycle.
- Undefined: `mem_ready` is ignored and each memory state lasts exactly one cycle.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH);
  - `alu_op` and `alu_control` encodings;
  - `imm_src` encodings.
- Sub-module `alu_decoder` (combinational): `alu_op`, `funct3`, `op[5]`, `funct7b5` → `alu_control`.

## Test plan
- lw x5,8(x1), 0x0080A283, macro off: states FETCH→DECODE→MEMADR→MEMREAD→MEMWB. `imm_src`=00. `reg_write` only in MEMWB with `result_src`=01. `instr_retire` in cycle 5.
- sub, op 0110011, f3 000, f7b5 1: EXECUTER `alu_control`=001. With f7b5 0: 000. addi with f7b5 1: 000.
- beq: `zero`=1 → `pc_write`=1 in BEQ, next state FETCH. `zero`=0 → `pc_write`=0.
- sw, macro on, `mem_ready` low 3 cycles in MEMWRITE: `mem_write` high 4 cycles. FETCH entered the cycle after `mem_ready`=1. Single `instr_retire`.
- op 0000000 in DECODE → TRAP, `illegal_instr`=1 and held. `reset` → FETCH with all strobes 0.
- `reset` asserted in MEMREAD: no `reg_write`, next state FETCH, `illegal_instr`=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Immediate format follows the opcode alone, independent of FSM state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU decoder: maps the FSM's alu_op plus instruction fields to alu_control.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    // Fixed add/sub for address and compare phases, funct3 decode otherwise.
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit (Moore FSM) for a shared-ALU RV32I datapath.
// Optional MC_CTRL_MEM_WAIT_EN: memory phases stall until mem_ready.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic [2:0] alu_control,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       instr_retire,
    output logic       illegal_instr
);

    state_t     r_state;
    logic       w_mem_ok;
    logic [1:0] w_alu_op;
    logic       w_pc_update;
    logic       w_branch;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign w_mem_ok = mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_ok = 1'b1;
`endif

    // State sequencing; memory phases stall while the memory is not ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    r_state <= w_mem_ok ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_RTYPE:          r_state <= S_EXECUTER;
                        OP_ITYPE:          r_state <= S_EXECUTEI;
                        OP_JAL:            r_state <= S_JAL;
                        OP_BRANCH:         r_state <= S_BEQ;
                        default:           r_state <= S_TRAP;
                    endcase
                end
                S_MEMADR:   r_state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  r_state <= w_mem_ok ? S_MEMWB : S_MEMREAD;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: r_state <= w_mem_ok ? S_FETCH : S_MEMWRITE;
                S_EXECUTER: r_state <= S_ALUWB;
                S_EXECUTEI: r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
                S_BEQ:      r_state <= S_FETCH;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Per-state datapath controls; reset shows FETCH muxes with strobes off.
    always_comb begin
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        result_src    = RES_ALUOUT;
        adr_src       = 1'b0;
        w_alu_op      = ALUOP_ADD;
        ir_write      = 1'b0;
        w_pc_update   = 1'b0;
        w_branch      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        instr_retire  = 1'b0;
        illegal_instr = 1'b0;
        if (reset) begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
        end else begin
            case (r_state)
                S_FETCH: begin
                    alu_src_b   = SRCB_FOUR;
                    result_src  = RES_ALURESULT;
                    ir_write    = w_mem_ok;
                    w_pc_update = w_mem_ok;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMREAD: adr_src = 1'b1;
                S_MEMWB: begin
                    result_src   = RES_DATA;
                    reg_write    = 1'b1;
                    instr_retire = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src      = 1'b1;
                    mem_write    = 1'b1;
                    instr_retire = w_mem_ok;
                end
                S_EXECUTER: begin
                    alu_src_a = SRCA_RS1;
                    w_alu_op  = ALUOP_FUNCT;
                end
                S_EXECUTEI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    w_alu_op  = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    reg_write    = 1'b1;
                    instr_retire = 1'b1;
                end
                S_JAL: begin
                    alu_src_a   = SRCA_OLDPC;
                    alu_src_b   = SRCB_FOUR;
                    w_pc_update = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a    = SRCA_RS1;
                    w_alu_op     = ALUOP_SUB;
                    w_branch     = 1'b1;
                    instr_retire = 1'b1;
                end
                S_TRAP:  illegal_instr = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc_write = w_pc_update | (w_branch & zero);
    assign imm_src  = imm_src_of(op);

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op5         (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (alu_control)
    );

endmodule
